// File: rtl/key_entry_controller_pkg.sv
// Shared types and constants for the key entry controller and its debouncer.
package key_entry_controller_pkg;

    // Key FSM: wait for a press, qualify it, then wait for a full release
    typedef enum logic [1:0] {
        KEY_READY    = 2'd0,
        KEY_DEBOUNCE = 2'd1,
        KEY_HELD     = 2'd2
    } key_state_t;

    // Lockout FSM: normal operation or timed key blocking
    typedef enum logic {
        LOCK_ARMED   = 1'b0,
        LOCK_LOCKOUT = 1'b1
    } lock_state_t;

    localparam logic [3:0] KEY_NONE = 4'b0000;

    // Isolate the lowest-index set bit so simultaneous presses resolve to key 0 first
    function automatic logic [3:0] lowest_key(input logic [3:0] act);
        return act & (~act + 4'd1);
    endfunction

endpackage

// File: rtl/key_entry_controller_key_debouncer.sv
// Synchronises the active-low keys, picks one key, debounces it and emits a
// single-cycle one-hot strobe. force_held parks the FSM in HELD so a key that is
// still down when forcing ends must be released before a new press is accepted.
module key_debouncer
    import key_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       force_held,
    output logic [3:0] key_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync_1;
    logic [3:0]    sync_2;
    logic [3:0]    act;
    logic [3:0]    captured;
    logic [CW-1:0] cnt;
    key_state_t    state;

    assign act = ~sync_2;

    // Two-flop synchroniser; resets to all keys released
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 4'b1111;
            sync_2 <= 4'b1111;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values and form a real two-flop chain.
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    // Key FSM with shared debounce / release counter and registered strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= KEY_READY;
            cnt      <= '0;
            captured <= KEY_NONE;
            key_out  <= KEY_NONE;
        end else begin
            // NOTE: default to no strobe every cycle so key_out is high for exactly one cycle.
            key_out <= KEY_NONE;
            if (force_held) begin
                state <= KEY_HELD;
                cnt   <= '0;
            end else begin
                case (state)
                    KEY_READY: begin
                        if (act != KEY_NONE) begin
                            captured <= lowest_key(act);
                            cnt      <= '0;
                            state    <= KEY_DEBOUNCE;
                        end
                    end
                    KEY_DEBOUNCE: begin
                        if ((act & captured) == KEY_NONE) begin
                            state <= KEY_READY;
                        end else if (cnt == CNT_LAST) begin
                            key_out <= captured;
                            cnt     <= '0;
                            state   <= KEY_HELD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    KEY_HELD: begin
                        if (act != KEY_NONE) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= KEY_READY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= KEY_READY;
                endcase
            end
        end
    end

endmodule

// File: rtl/key_entry_controller.sv
// Key entry front end for the lock FSM: debounced key strobes plus an attempt
// lockout with exponential backoff driven by the lock FSM's error/lock flags.
module key_entry_controller
    import key_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int MAX_ATTEMPTS      = 3,
    parameter int LOCKOUT_CYCLES    = 250000000,
    parameter int MAX_BACKOFF_SHIFT = 3,
    parameter int TIMER_WIDTH       = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [3:0]                            key_n,
    input  logic                                  error_flag,
    input  logic                                  lock_flag,
    output logic [3:0]                            key_out,
    output logic                                  lockout_flag,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_count,
    output logic [TIMER_WIDTH-1:0]                lockout_remaining
);

    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int SW = (MAX_BACKOFF_SHIFT > 0) ? $clog2(MAX_BACKOFF_SHIFT + 1) : 1;
    localparam logic [FW-1:0]          LAST_FAIL    = FW'(MAX_ATTEMPTS - 1);
    localparam logic [SW-1:0]          SHIFT_MAX    = SW'(MAX_BACKOFF_SHIFT);
    localparam logic [TIMER_WIDTH-1:0] LOCKOUT_BASE = TIMER_WIDTH'(LOCKOUT_CYCLES);

    logic        error_q;
    logic        lock_q;
    logic        err_evt;
    logic        unlock_evt;
    logic [SW-1:0] shift;
    lock_state_t lock_state;
    logic [3:0]  deb_key;

    assign err_evt      = error_flag & ~error_q;
    assign unlock_evt   = ~lock_flag & lock_q;
    assign lockout_flag = (lock_state == LOCK_LOCKOUT);
    // Also mask here so a strobe registered on the lockout-entry edge never escapes
    assign key_out      = lockout_flag ? KEY_NONE : deb_key;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .force_held (lockout_flag),
        .key_out    (deb_key)
    );

    // Delay the lock FSM flags by one cycle for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            error_q <= error_flag;
            lock_q  <= lock_flag;
        end
    end

    // Attempt counting, backoff and lockout timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_state        <= LOCK_ARMED;
            fail_count        <= '0;
            shift             <= '0;
            lockout_remaining <= '0;
        end else begin
            case (lock_state)
                LOCK_ARMED: begin
                    if (unlock_evt) begin
                        fail_count <= '0;
                        shift      <= '0;
                    end else if (err_evt) begin
                        if (fail_count == LAST_FAIL) begin
                            lock_state        <= LOCK_LOCKOUT;
                            lockout_remaining <= LOCKOUT_BASE << shift;
                            fail_count        <= '0;
                            if (shift != SHIFT_MAX) begin
                                shift <= shift + 1'b1;
                            end
                        end else begin
                            fail_count <= fail_count + 1'b1;
                        end
                    end
                end
                LOCK_LOCKOUT: begin
                    if (lockout_remaining <= TIMER_WIDTH'(1)) begin
                        lockout_remaining <= '0;
                        lock_state        <= LOCK_ARMED;
                    end else begin
                        lockout_remaining <= lockout_remaining - 1'b1;
                    end
                end
                default: lock_state <= LOCK_ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_controller.sv
// Scoreboard bench: stimulus pushes expected strobes (key, cycle) into a queue and
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_key_entry_controller;

    localparam int D   = 4;
    localparam int LAT = D + 3;  // drive cycle -> cycle at which the strobe is observed

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_n = 4'b1111;
    logic        error_flag = 1'b0;
    logic        lock_flag  = 1'b0;
    logic [3:0]  key_out;
    logic        lockout_flag;
    logic [1:0]  fail_count;
    logic [31:0] lockout_remaining;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] key;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    key_entry_controller #(
        .DEBOUNCE_CYCLES  (D),
        .MAX_ATTEMPTS     (3),
        .LOCKOUT_CYCLES   (10),
        .MAX_BACKOFF_SHIFT(2),
        .TIMER_WIDTH      (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .key_n            (key_n),
        .error_flag       (error_flag),
        .lock_flag        (lock_flag),
        .key_out          (key_out),
        .lockout_flag     (lockout_flag),
        .fail_count       (fail_count),
        .lockout_remaining(lockout_remaining)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, want, want, cyc);
        end
    endtask

    // Monitor: every nonzero key_out must match the oldest expected strobe
    always @(negedge clock) begin
        exp_t e;
        if (!reset && key_out !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got key_out=%b at cycle %0d, expected none",
                         key_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_key", {28'd0, key_out}, {28'd0, e.key});
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive a key pattern just after an edge and register the strobe it should cause
    task automatic press(input logic [3:0] k, input logic [3:0] want_key);
        @(posedge clock);
        #1 key_n = k;
        exp_q.push_back('{key: want_key, cyc: cyc + LAT});
    endtask

    task automatic pulse_error();
        @(posedge clock);
        #1 error_flag = 1'b1;
        @(posedge clock);
        #1 error_flag = 1'b0;
    endtask

    task automatic pulse_unlock();
        @(posedge clock);
        #1 lock_flag = 1'b1;
        repeat (2) @(posedge clock);
        #1 lock_flag = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Three errors -> lockout of 'load' cycles; optionally press keys inside it,
    // optionally stop when the remaining count reaches stop_at
    task automatic run_lockout(input string tag, input int load, input bit keys, input int stop_at);
        pulse_error();
        @(negedge clock);
        check({tag, "_fail1"}, {30'd0, fail_count}, 1);
        pulse_error();
        @(negedge clock);
        check({tag, "_fail2"}, {30'd0, fail_count}, 2);
        pulse_error();
        @(negedge clock);
        check({tag, "_fail_clr"}, {30'd0, fail_count}, 0);
        for (int i = 0; i < load; i++) begin
            check({tag, "_flag"}, {31'd0, lockout_flag}, 1);
            check({tag, "_remaining"}, lockout_remaining, load - i);
            if (load - i == stop_at) return;
            if (keys && i == 2) key_n = 4'b1011;
            if (keys && i == 6) key_n = 4'b1111;
            if (keys && i == 8) key_n = 4'b1011;
            @(negedge clock);
        end
        check({tag, "_exit_flag"}, {31'd0, lockout_flag}, 0);
        check({tag, "_exit_remaining"}, lockout_remaining, 0);
    endtask

    initial begin
        // Reset state
        wait_cycles(3);
        check("rst_key_out", {28'd0, key_out}, 0);
        check("rst_lockout_flag", {31'd0, lockout_flag}, 0);
        check("rst_fail_count", {30'd0, fail_count}, 0);
        check("rst_remaining", lockout_remaining, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_cycles(3);

        // Single key 1 held then released: one strobe, no repeat on release
        press(4'b1101, 4'b0010);
        wait_cycles(10);
        key_n = 4'b1111;
        wait_cycles(10);

        // Bouncing key 0: two low samples then two high, three times -> nothing
        for (int r = 0; r < 3; r++) begin
            key_n = 4'b1110;
            wait_cycles(2);
            key_n = 4'b1111;
            wait_cycles(2);
        end
        wait_cycles(10);

        // Keys 0 and 3 together -> key 0 wins; key 3 left held gives nothing
        press(4'b0110, 4'b0001);
        wait_cycles(10);
        key_n = 4'b0111;
        wait_cycles(15);
        key_n = 4'b1111;
        wait_cycles(10);

        // First lockout with presses inside it; key 2 still held at exit
        run_lockout("lock1", 10, 1'b1, -1);
        wait_cycles(10);
        key_n = 4'b1111;
        wait_cycles(10);

        // Backoff without unlock: 20, 40, then saturated 40
        run_lockout("lock2", 20, 1'b0, -1);
        run_lockout("lock3", 40, 1'b0, -1);
        run_lockout("lock4", 40, 1'b0, -1);

        // An unlock clears the partial fail count and the backoff
        pulse_error();
        @(negedge clock);
        check("pre_unlock_fail", {30'd0, fail_count}, 1);
        pulse_unlock();
        @(negedge clock);
        check("post_unlock_fail", {30'd0, fail_count}, 0);
        run_lockout("lock5", 10, 1'b0, 5);

        // Reset in the middle of a lockout
        #2 reset = 1'b1;
        #1;
        check("midrst_key_out", {28'd0, key_out}, 0);
        check("midrst_flag", {31'd0, lockout_flag}, 0);
        check("midrst_fail", {30'd0, fail_count}, 0);
        check("midrst_remaining", lockout_remaining, 0);
        wait_cycles(2);
        @(negedge clock);
        reset = 1'b0;
        wait_cycles(2);

        // Next press after reset is accepted normally
        press(4'b1110, 4'b0001);
        wait_cycles(12);
        key_n = 4'b1111;
        wait_cycles(10);

        // Reset in the middle of a debounce: no strobe
        @(posedge clock);
        #1 key_n = 4'b1101;
        wait_cycles(4);
        reset = 1'b1;
        key_n = 4'b1111;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(12);

        // Every expected strobe must have been seen
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
